// File: rtl/startup_config_fsm.sv
// startup_config_fsm
//
// Power-up configuration menu for the coin-operated game front end. Debounced
// joystick events edit NUM_SETTINGS game settings (coins per round, coins to
// insert, insert wait time, ...). Up/down step the selected setting and
// saturate it to [MIN_VAL, MAX_VAL]. Left/right move the selection and wrap
// around. A press finishes configuration. Exactly one action is taken per
// stick_en assertion.
//
// Optional feature: define STARTUP_CONFIG_AUTOREPEAT_EN to let a held up/down
// repeat after REPEAT_DELAY cycles, and then every REPEAT_PERIOD cycles.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   stick_en        in   stick event valid
//   stick_direction in   3'b000 up, 001 down, 010 left, 011 right, 100 press
//   restart         in   leave DONE and resume editing
//   sel             out  index of the setting being edited
//   settings        out  setting i at bits [i*W +: W]
//   config_done     out  high while in DONE
//   done_pulse      out  one-cycle strobe on entry to DONE
module startup_config_fsm #(
  parameter int NUM_SETTINGS  = 3,
  parameter int W             = 4,
  parameter int DEFAULT_VAL   = 5,
  parameter int MIN_VAL       = 1,
  parameter int MAX_VAL       = 15,
  parameter int STEP          = 1,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4,
  localparam int SEL_W = (NUM_SETTINGS > 1) ? $clog2(NUM_SETTINGS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stick_en,
  input  logic [2:0]                stick_direction,
  input  logic                      restart,
  output logic [SEL_W-1:0]          sel,
  output logic [NUM_SETTINGS*W-1:0] settings,
  output logic                      config_done,
  output logic                      done_pulse
);

  localparam logic [2:0] DIR_UP    = 3'b000;
  localparam logic [2:0] DIR_DOWN  = 3'b001;
  localparam logic [2:0] DIR_LEFT  = 3'b010;
  localparam logic [2:0] DIR_RIGHT = 3'b011;
  localparam logic [2:0] DIR_PRESS = 3'b100;

  // Saturation arithmetic is done one bit wider so an increment can never wrap.
  localparam logic [W:0] STEP_X     = (W+1)'(STEP);
  localparam logic [W:0] MAX_X      = (W+1)'(MAX_VAL);
  localparam logic [W:0] MIN_STEP_X = (W+1)'(MIN_VAL + STEP);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SETTINGS - 1);

  // Elaboration-time sanity checks on the parameter set.
  if (NUM_SETTINGS < 2 || NUM_SETTINGS > 16) begin : g_bad_num
    $error("NUM_SETTINGS must be 2..16");
  end
  if (!(MIN_VAL <= DEFAULT_VAL && DEFAULT_VAL <= MAX_VAL && MAX_VAL < (1 << W))) begin : g_bad_range
    $error("need MIN_VAL <= DEFAULT_VAL <= MAX_VAL < 2**W");
  end
  if (STEP < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_step
    $error("STEP, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {
    WAIT_STICK = 2'd0,
    HOLD       = 2'd1,
    DONE       = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [W-1:0]     set_q [NUM_SETTINGS];
  logic [W-1:0]     set_d [NUM_SETTINGS];
  logic             config_done_q, config_done_d;
  logic             done_pulse_q, done_pulse_d;

`ifdef STARTUP_CONFIG_AUTOREPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_thr;
  logic             rep_q, rep_d;          // first repeat already issued
  logic [2:0]       rep_dir_q, rep_dir_d;  // direction accepted on entry to HOLD
`endif

  function automatic logic [W-1:0] sat_up(input logic [W-1:0] v);
    logic [W:0] sum;
    sum = {1'b0, v} + STEP_X;
    if (sum > MAX_X) sat_up = W'(MAX_VAL);
    else             sat_up = sum[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_down(input logic [W-1:0] v);
    if ({1'b0, v} < MIN_STEP_X) sat_down = W'(MIN_VAL);
    else                        sat_down = v - W'(STEP);
  endfunction

  function automatic logic [W-1:0] step_val(input logic [W-1:0] v, input logic up);
    step_val = up ? sat_up(v) : sat_down(v);
  endfunction

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    set_d        = set_q;
    done_pulse_d = 1'b0;
`ifdef STARTUP_CONFIG_AUTOREPEAT_EN
    cnt_d     = '0;
    rep_d     = 1'b0;
    rep_dir_d = rep_dir_q;
    cnt_thr   = rep_q ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY);
`endif

    case (state_q)
      WAIT_STICK: begin
        if (stick_en) begin
`ifdef STARTUP_CONFIG_AUTOREPEAT_EN
          rep_dir_d = stick_direction;
`endif
          case (stick_direction)
            DIR_UP, DIR_DOWN: begin
              set_d[sel_q] = step_val(set_q[sel_q], stick_direction == DIR_UP);
              state_d      = HOLD;
            end
            DIR_LEFT: begin
              sel_d   = (sel_q == '0) ? SEL_LAST : sel_q - 1'b1;
              state_d = HOLD;
            end
            DIR_RIGHT: begin
              sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
              state_d = HOLD;
            end
            DIR_PRESS: begin
              state_d      = DONE;
              done_pulse_d = 1'b1;
            end
            default: ;  // reserved codes are ignored
          endcase
        end
      end

      HOLD: begin
        if (!stick_en) begin
          state_d = WAIT_STICK;
        end
`ifdef STARTUP_CONFIG_AUTOREPEAT_EN
        // Only the accepted up/down keeps counting; any other direction
        // clears the counter and applies nothing.
        else if (stick_direction == rep_dir_q &&
                 (rep_dir_q == DIR_UP || rep_dir_q == DIR_DOWN)) begin
          if (cnt_q + 1'b1 >= cnt_thr) begin
            set_d[sel_q] = step_val(set_q[sel_q], rep_dir_q == DIR_UP);
            cnt_d        = '0;
            rep_d        = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            rep_d = rep_q;
          end
        end
`endif
      end

      DONE: begin
        // A stick still held during restart must be released before the
        // next action, so park in HOLD rather than WAIT_STICK.
        if (restart) begin
          state_d = stick_en ? HOLD : WAIT_STICK;
`ifdef STARTUP_CONFIG_AUTOREPEAT_EN
          rep_dir_d = DIR_PRESS;
`endif
        end
      end

      default: state_d = WAIT_STICK;
    endcase

    config_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_STICK;
      sel_q         <= '0;
      config_done_q <= 1'b0;
      done_pulse_q  <= 1'b0;
      for (int i = 0; i < NUM_SETTINGS; i++) set_q[i] <= W'(DEFAULT_VAL);
`ifdef STARTUP_CONFIG_AUTOREPEAT_EN
      cnt_q     <= '0;
      rep_q     <= 1'b0;
      rep_dir_q <= DIR_PRESS;
`endif
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      config_done_q <= config_done_d;
      done_pulse_q  <= done_pulse_d;
      set_q         <= set_d;
`ifdef STARTUP_CONFIG_AUTOREPEAT_EN
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      rep_dir_q <= rep_dir_d;
`endif
    end
  end

  for (genvar gi = 0; gi < NUM_SETTINGS; gi++) begin : g_pack
    assign settings[gi*W +: W] = set_q[gi];
  end

  assign sel         = sel_q;
  assign config_done = config_done_q;
  assign done_pulse  = done_pulse_q;

endmodule

// File: tb/tb_startup_config_fsm.sv
// Testbench for startup_config_fsm: directed literal checks plus a randomized
// run compared every cycle against an event-level model of the menu.
module tb_startup_config_fsm;

  localparam int N    = 3;
  localparam int W    = 4;
  localparam int DV   = 5;
  localparam int MINV = 1;
  localparam int MAXV = 15;
  localparam int STP  = 2;
  localparam int RD   = 8;
  localparam int RP   = 4;
  localparam int SW   = 2;

`ifdef STARTUP_CONFIG_AUTOREPEAT_EN
  localparam bit AR  = 1'b1;
  localparam int S1X = 11;  // sel1 after the held-up directed step
  localparam int S2X = 5;   // sel2 untouched
`else
  localparam bit AR  = 1'b0;
  localparam int S1X = 1;
  localparam int S2X = 7;   // one increment from a 10-cycle hold
`endif

  localparam logic [2:0] UP = 3'd0, DN = 3'd1, LT = 3'd2, RT = 3'd3, PR = 3'd4;

  logic             clk;
  logic             rst_n;
  logic             stick_en;
  logic [2:0]       stick_direction;
  logic             restart;
  logic [SW-1:0]    sel;
  logic [N*W-1:0]   settings;
  logic             config_done;
  logic             done_pulse;

  startup_config_fsm #(
    .NUM_SETTINGS(N), .W(W), .DEFAULT_VAL(DV), .MIN_VAL(MINV), .MAX_VAL(MAXV),
    .STEP(STP), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stick_en(stick_en), .stick_direction(stick_direction),
    .restart(restart), .sel(sel), .settings(settings), .config_done(config_done),
    .done_pulse(done_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Behavioural model: menu values, selection, done flag, whether a new
  // stick assertion may be accepted, and the held-repeat bookkeeping.
  int m_set [N];
  int m_sel;
  bit m_done, m_pulse, m_armed;
  int m_hdir, m_k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_set[i] = DV;
    m_sel = 0; m_done = 0; m_pulse = 0; m_armed = 1; m_hdir = 7; m_k = 0;
  endtask

  task automatic m_apply(input int d);
    case (d)
      0: m_set[m_sel] = (m_set[m_sel] + STP > MAXV) ? MAXV : m_set[m_sel] + STP;
      1: m_set[m_sel] = (m_set[m_sel] < MINV + STP) ? MINV : m_set[m_sel] - STP;
      2: m_sel = (m_sel + N - 1) % N;
      3: m_sel = (m_sel + 1) % N;
      default: ;
    endcase
  endtask

  task automatic m_step(input bit en, input int d, input bit rs);
    m_pulse = 0;
    if (m_done) begin
      if (rs) begin m_done = 0; m_armed = !en; m_hdir = 7; m_k = 0; end
    end else if (m_armed) begin
      if (en && d <= 4) begin
        if (d == 4) begin m_done = 1; m_pulse = 1; end
        else m_apply(d);
        m_armed = 0; m_hdir = d; m_k = 0;
      end
    end else begin
      if (!en) m_armed = 1;
      else if (AR && d == m_hdir && m_hdir <= 1) begin
        m_k++;
        if (m_k == RD || (m_k > RD && (m_k - RD) % RP == 0)) m_apply(m_hdir);
      end else m_k = 0;
    end
  endtask

  function automatic logic [N*W-1:0] m_pack();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(m_set[i]);
    return r;
  endfunction

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("settings", 32'(settings), 32'(m_pack()));
      chk("sel", 32'(sel), 32'(m_sel));
      chk("config_done", 32'(config_done), 32'(m_done));
      chk("done_pulse", 32'(done_pulse), 32'(m_pulse));
    end
  end

  task automatic cyc(input logic en, input logic [2:0] d, input logic rs);
    stick_en = en; stick_direction = d; restart = rs;
    @(posedge clk);
    if (rst_n) m_step(en, int'(d), rs);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic en_r, rs_r;
    logic [2:0] d_r;
    int r;

    stick_en = 0; stick_direction = 0; restart = 0;
    rst_n = 0; m_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    chk("reset_settings", 32'(settings), 32'h555);
    chk("reset_sel", 32'(sel), 0);
    chk("reset_done", 32'(config_done), 0);
    chk("reset_pulse", 32'(done_pulse), 0);

    // Six up pulses on setting 0 with saturation at 15.
    for (int i = 0; i < 6; i++) begin
      cyc(1, UP, 0);
      chk("up_seq", 32'(settings[3:0]), (i < 5) ? 32'(7 + 2*i) : 32'd15);
      cyc(0, UP, 0);
    end

    cyc(1, LT, 0); chk("left_wrap", 32'(sel), 2); cyc(0, 0, 0);
    cyc(1, RT, 0); chk("right_wrap", 32'(sel), 0); cyc(0, 0, 0);
    cyc(1, RT, 0); cyc(0, 0, 0);
    cyc(1, DN, 0); chk("down_5_3", 32'(settings[7:4]), 3); cyc(0, 0, 0);
    cyc(1, DN, 0); chk("down_3_1", 32'(settings[7:4]), 1); cyc(0, 0, 0);
    cyc(1, DN, 0); chk("down_sat", 32'(settings[7:4]), 1); cyc(0, 0, 0);
    cyc(1, RT, 0); cyc(0, 0, 0);

`ifdef STARTUP_CONFIG_AUTOREPEAT_EN
    // Held up on sel1 (value 1): accept, then repeats at +8, +12, +16, +20.
    cyc(1, LT, 0); cyc(0, 0, 0);
    for (int i = 0; i <= 20; i++) cyc(1, UP, 0);
    cyc(0, 0, 0);
    chk("autorepeat_hold", 32'(settings[7:4]), 32'(S1X));
    cyc(1, RT, 0); cyc(0, 0, 0);
`else
    for (int i = 0; i < 10; i++) cyc(1, UP, 0);
    cyc(0, 0, 0);
    chk("hold_one_action", 32'(settings[11:8]), 32'(S2X));
    chk("hold_sel1_kept", 32'(settings[7:4]), 32'(S1X));
`endif

    // Reserved code does nothing and leaves the stick acceptable immediately.
    cyc(1, 3'd5, 0); chk("reserved_nochange", 32'(settings[11:8]), 32'(S2X));
    cyc(1, UP, 0);   chk("after_reserved_up", 32'(settings[11:8]), 32'(S2X + 2));
    cyc(0, 0, 0);

    // Press, stick ignored in DONE, restart resumes with values kept.
    cyc(1, PR, 0); chk("press_done", 32'(config_done), 1); chk("press_pulse", 32'(done_pulse), 1);
    cyc(1, UP, 0); chk("pulse_drop", 32'(done_pulse), 0); chk("done_held", 32'(config_done), 1);
    chk("done_frozen", 32'(settings[11:8]), 32'(S2X + 2));
    cyc(0, 0, 0);
    cyc(0, 0, 1);  chk("restart_clear", 32'(config_done), 0);
    cyc(1, DN, 0); chk("edit_after_restart", 32'(settings[11:8]), 32'(S2X));
    cyc(0, 0, 0);

    // Restart with the stick held needs a fresh assertion.
    cyc(1, PR, 0); cyc(0, 0, 0);
    cyc(1, UP, 1); chk("restart_stick_done", 32'(config_done), 0);
    chk("restart_stick_ignored", 32'(settings[11:8]), 32'(S2X));
    cyc(1, UP, 0); chk("needs_fresh", 32'(settings[11:8]), 32'(S2X));
    cyc(0, 0, 0);
    cyc(1, UP, 0); chk("fresh_accept", 32'(settings[11:8]), 32'(S2X + 2));
    cyc(0, 0, 0);

    // Asynchronous reset in the middle of a hold.
    cyc(1, LT, 0); cyc(1, LT, 0); chk("hold_sel", 32'(sel), 1);
    #1 rst_n = 0; m_reset();
    #1;
    chk("async_settings", 32'(settings), 32'h555);
    chk("async_sel", 32'(sel), 0);
    chk("async_done", 32'(config_done), 0);
    stick_en = 0;
    @(posedge clk); #2 rst_n = 1;

    // Randomized run, with inputs often held to exercise HOLD and repeats.
    en_r = 0; d_r = 0; rs_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < (AR ? 3 : 5)) begin
        en_r = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 15);
        d_r = (r < 13) ? 3'(r % 4) : (r == 13) ? PR : 3'(5 + r % 3);
        rs_r = ($urandom_range(0, 3) == 0);
      end
      cyc(en_r, d_r, rs_r);
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
